// File: rtl/imgproc_pkg.sv
// Shared constants and helpers for the pixel pair filter.
package imgproc_pkg;

  localparam int PIX_W = 8;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_BRIGHT = 2'd1;
  localparam logic [1:0] MODE_INV    = 2'd2;
  localparam logic [1:0] MODE_THR    = 2'd3;

  // Bits needed to count the pairs of one frame (never less than one bit).
  function automatic int pair_cnt_w(input int width, input int height);
    int pairs;
    pairs = (width * height) / 32'sd2;
    return (pairs > 32'sd2) ? $clog2(pairs) : 32'sd1;
  endfunction

  // Saturate a 10-bit signed brightness sum into the 0..255 channel range.
  function automatic logic [PIX_W-1:0] clamp_u8(input logic signed [PIX_W+1:0] v);
    logic [PIX_W-1:0] r;
    if (v[PIX_W+1]) begin
      r = 8'h00;
    end else if (v[PIX_W]) begin
      r = 8'hFF;
    end else begin
      r = v[PIX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pixel_pair_filter_if.sv
// Two-pixel stream in/out plus per-frame configuration inputs.
interface pixel_pair_filter_if;
  import imgproc_pkg::*;

  logic             hsync_in;
  logic [PIX_W-1:0] DATA_R0, DATA_G0, DATA_B0;
  logic [PIX_W-1:0] DATA_R1, DATA_G1, DATA_B1;
  logic [1:0]       MODE;
  logic [PIX_W-1:0] OFFSET;
  logic [PIX_W-1:0] THRESH;
  logic             hsync;
  logic [PIX_W-1:0] DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0;
  logic [PIX_W-1:0] DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1;
  logic             frame_done;

  modport master (
    output hsync_in, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1,
    output MODE, OFFSET, THRESH,
    input  hsync, DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
    input  DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1, frame_done
  );

  modport slave (
    input  hsync_in, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1,
    input  MODE, OFFSET, THRESH,
    output hsync, DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
    output DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1, frame_done
  );
endinterface

// File: rtl/pixel_op.sv
// One RGB pixel through both pipeline stages: intermediates, then clamp/select.
module pixel_op
  import imgproc_pkg::*;
(
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             vld_in,
  input  logic             vld_s1,
  input  logic [PIX_W-1:0] offset,
  input  logic [1:0]       mode_s1,
  input  logic [PIX_W-1:0] thresh_s1,
  input  logic [PIX_W-1:0] r_in,
  input  logic [PIX_W-1:0] g_in,
  input  logic [PIX_W-1:0] b_in,
  output logic [PIX_W-1:0] r_out,
  output logic [PIX_W-1:0] g_out,
  output logic [PIX_W-1:0] b_out
);

  localparam int NCH = 3;

  logic        [PIX_W-1:0] x_s   [NCH];
  logic        [PIX_W-1:0] x_r   [NCH];
  logic signed [PIX_W+1:0] sum_s [NCH];
  logic signed [PIX_W+1:0] sum_r [NCH];
  logic        [PIX_W+1:0] gray_s;
  logic        [PIX_W+1:0] gray_r;
  logic                    thr_hit_s;
  logic        [PIX_W-1:0] res_s [NCH];
  logic        [PIX_W-1:0] out_r [NCH];

  assign x_s[0] = r_in;
  assign x_s[1] = g_in;
  assign x_s[2] = b_in;

  // Stage-1 arithmetic: signed brightness sums and the un-shifted gray sum R+2G+B.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      sum_s[i] = $signed({2'b00, x_s[i]}) + $signed({{2{offset[PIX_W-1]}}, offset});
    end
    gray_s = {2'b00, r_in} + {1'b0, g_in, 1'b0} + {2'b00, b_in};
  end

  // Stage-1 registers; zero when no pair is entering.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < NCH; i++) begin
        x_r[i]   <= 8'h00;
        sum_r[i] <= 10'sd0;
      end
      gray_r <= 10'd0;
    end else if (vld_in) begin
      for (int i = 0; i < NCH; i++) begin
        x_r[i]   <= x_s[i];
        sum_r[i] <= sum_s[i];
      end
      gray_r <= gray_s;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        x_r[i]   <= 8'h00;
        sum_r[i] <= 10'sd0;
      end
      gray_r <= 10'd0;
    end
  end

  // (R+2G+B)>>2 >= T is the same test as R+2G+B >= 4T, which keeps all gray bits.
  assign thr_hit_s = (gray_r >= {thresh_s1, 2'b00});

  // Stage-2 operation select per channel.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      res_s[i] = x_r[i];
      case (mode_s1)
        MODE_PASS:   res_s[i] = x_r[i];
        MODE_BRIGHT: res_s[i] = clamp_u8(sum_r[i]);
        MODE_INV:    res_s[i] = 8'hFF - x_r[i];
        MODE_THR:    res_s[i] = thr_hit_s ? 8'hFF : 8'h00;
        default:     res_s[i] = x_r[i];
      endcase
    end
  end

  // Stage-2 output registers; zero whenever the output pair is not valid.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < NCH; i++) out_r[i] <= 8'h00;
    end else if (vld_s1) begin
      for (int i = 0; i < NCH; i++) out_r[i] <= res_s[i];
    end else begin
      for (int i = 0; i < NCH; i++) out_r[i] <= 8'h00;
    end
  end

  assign r_out = out_r[0];
  assign g_out = out_r[1];
  assign b_out = out_r[2];

endmodule

// File: rtl/pixel_pair_filter.sv
// Two-pixel point filter: pair counter, per-frame config latch, valid/last pipeline.
module pixel_pair_filter
  import imgproc_pkg::*;
#(
  parameter int WIDTH  = 340,
  parameter int HEIGHT = 230
) (
  input logic               HCLK,
  input logic               HRESET,
  pixel_pair_filter_if.slave bus
);

  localparam int                 PAIRS    = (WIDTH * HEIGHT) / 2;
  localparam int                 CNT_W    = pair_cnt_w(WIDTH, HEIGHT);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(PAIRS - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(32'd1);

  logic [CNT_W-1:0] pair_cnt_r;
  logic [1:0]       cfg_mode_r;
  logic [PIX_W-1:0] cfg_offset_r;
  logic [PIX_W-1:0] cfg_thresh_r;
  logic             first_s;
  logic             last_s;
  logic [1:0]       mode_eff_s;
  logic [PIX_W-1:0] offset_eff_s;
  logic [PIX_W-1:0] thresh_eff_s;
  logic             vld1_r;
  logic             last1_r;
  logic [1:0]       mode1_r;
  logic [PIX_W-1:0] thresh1_r;
  logic             vld2_r;
  logic             done2_r;
  logic [PIX_W-1:0] r0_s, g0_s, b0_s, r1_s, g1_s, b1_s;

  assign first_s = bus.hsync_in && (pair_cnt_r == {CNT_W{1'b0}});
  assign last_s  = (pair_cnt_r == LAST_CNT);

  // Pair 0 uses the live config inputs; every later pair uses the latched copy.
  always_comb begin
    mode_eff_s   = cfg_mode_r;
    offset_eff_s = cfg_offset_r;
    thresh_eff_s = cfg_thresh_r;
    if (first_s) begin
      mode_eff_s   = bus.MODE;
      offset_eff_s = bus.OFFSET;
      thresh_eff_s = bus.THRESH;
    end else begin
      mode_eff_s   = cfg_mode_r;
      offset_eff_s = cfg_offset_r;
      thresh_eff_s = cfg_thresh_r;
    end
  end

  // Pair counter, wrapping after the last pair of the frame.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pair_cnt_r <= {CNT_W{1'b0}};
    end else if (bus.hsync_in) begin
      pair_cnt_r <= last_s ? {CNT_W{1'b0}} : pair_cnt_r + CNT_ONE;
    end else begin
      pair_cnt_r <= pair_cnt_r;
    end
  end

  // Config latch, loaded only at the first pair of a frame.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cfg_mode_r   <= 2'd0;
      cfg_offset_r <= 8'h00;
      cfg_thresh_r <= 8'h00;
    end else if (first_s) begin
      cfg_mode_r   <= bus.MODE;
      cfg_offset_r <= bus.OFFSET;
      cfg_thresh_r <= bus.THRESH;
    end else begin
      cfg_mode_r   <= cfg_mode_r;
      cfg_offset_r <= cfg_offset_r;
      cfg_thresh_r <= cfg_thresh_r;
    end
  end

  // Stage-1 control: valid, last flag and the config this pair travels with.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      vld1_r    <= 1'b0;
      last1_r   <= 1'b0;
      mode1_r   <= 2'd0;
      thresh1_r <= 8'h00;
    end else if (bus.hsync_in) begin
      vld1_r    <= 1'b1;
      last1_r   <= last_s;
      mode1_r   <= mode_eff_s;
      thresh1_r <= thresh_eff_s;
    end else begin
      vld1_r    <= 1'b0;
      last1_r   <= 1'b0;
      mode1_r   <= 2'd0;
      thresh1_r <= 8'h00;
    end
  end

  // Stage-2 control: output valid and end-of-frame pulse.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      vld2_r  <= 1'b0;
      done2_r <= 1'b0;
    end else begin
      vld2_r  <= vld1_r;
      done2_r <= vld1_r && last1_r;
    end
  end

  pixel_op u_pix0 (
    .HCLK(HCLK), .HRESET(HRESET), .vld_in(bus.hsync_in), .vld_s1(vld1_r),
    .offset(offset_eff_s), .mode_s1(mode1_r), .thresh_s1(thresh1_r),
    .r_in(bus.DATA_R0), .g_in(bus.DATA_G0), .b_in(bus.DATA_B0),
    .r_out(r0_s), .g_out(g0_s), .b_out(b0_s)
  );

  pixel_op u_pix1 (
    .HCLK(HCLK), .HRESET(HRESET), .vld_in(bus.hsync_in), .vld_s1(vld1_r),
    .offset(offset_eff_s), .mode_s1(mode1_r), .thresh_s1(thresh1_r),
    .r_in(bus.DATA_R1), .g_in(bus.DATA_G1), .b_in(bus.DATA_B1),
    .r_out(r1_s), .g_out(g1_s), .b_out(b1_s)
  );

  assign bus.hsync         = vld2_r;
  assign bus.frame_done    = done2_r;
  assign bus.DATA_WRITE_R0 = r0_s;
  assign bus.DATA_WRITE_G0 = g0_s;
  assign bus.DATA_WRITE_B0 = b0_s;
  assign bus.DATA_WRITE_R1 = r1_s;
  assign bus.DATA_WRITE_G1 = g1_s;
  assign bus.DATA_WRITE_B1 = b1_s;

endmodule

// File: tb/tb_pixel_pair_filter.sv
// Self-checking bench for pixel_pair_filter: vector table, directed sequences, random vs model.
module tb_pixel_pair_filter;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int PAIRS = W * H / 2;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;

  pixel_pair_filter_if bus();

  pixel_pair_filter #(.WIDTH(W), .HEIGHT(H)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic v; logic fd; logic [47:0] d; } out_t;
  typedef struct packed { logic [1:0] mode; logic [7:0] off; logic [7:0] thr; logic [47:0] din; logic [47:0] dout; } vec_t;

  out_t pend_q[$];
  out_t exp_now;
  int   m_cnt = 0, m_mode = 0, m_off = 0, m_thr = 0;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int op_chan(input int x, input int mode, input int off);
    int y;
    case (mode)
      1: begin y = x + off; if (y < 0) y = 0; if (y > 255) y = 255; end
      2: y = 255 - x;
      default: y = x;
    endcase
    return y;
  endfunction

  function automatic logic [23:0] op_pix(input int r, input int g, input int b,
                                         input int mode, input int off, input int thr);
    if (mode == 3) return (((r + 2 * g + b) / 4) >= thr) ? 24'hFFFFFF : 24'h000000;
    return {8'(op_chan(r, mode, off)), 8'(op_chan(g, mode, off)), 8'(op_chan(b, mode, off))};
  endfunction

  // Reference: frame-level rules applied per accepted pair, results delayed by the pipeline depth.
  task automatic model_edge();
    out_t nx;
    if (HRESET) begin
      pend_q.delete();
      pend_q.push_back('0);
      exp_now = '0;
      m_cnt = 0; m_mode = 0; m_off = 0; m_thr = 0;
    end else begin
      nx = '0;
      if (bus.hsync_in) begin
        if (m_cnt == 0) begin
          m_mode = int'(bus.MODE);
          m_off  = int'($signed(bus.OFFSET));
          m_thr  = int'(bus.THRESH);
        end
        nx.v  = 1'b1;
        nx.fd = (m_cnt == PAIRS - 1);
        nx.d  = {op_pix(bus.DATA_R0, bus.DATA_G0, bus.DATA_B0, m_mode, m_off, m_thr),
                 op_pix(bus.DATA_R1, bus.DATA_G1, bus.DATA_B1, m_mode, m_off, m_thr)};
        m_cnt = (m_cnt + 1) % PAIRS;
      end
      exp_now = pend_q.pop_front();
      pend_q.push_back(nx);
    end
  endtask

  function automatic logic [49:0] dut_out();
    return {bus.hsync, bus.frame_done, bus.DATA_WRITE_R0, bus.DATA_WRITE_G0, bus.DATA_WRITE_B0,
            bus.DATA_WRITE_R1, bus.DATA_WRITE_G1, bus.DATA_WRITE_B1};
  endfunction

  task automatic tick();
    @(posedge HCLK);
    model_edge();
    #1;
    check("model", dut_out(), exp_now);
  endtask

  task automatic set_pair(input logic v, input logic [47:0] d);
    bus.hsync_in = v;
    {bus.DATA_R0, bus.DATA_G0, bus.DATA_B0, bus.DATA_R1, bus.DATA_G1, bus.DATA_B1} = d;
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [7:0] o, input logic [7:0] t);
    bus.MODE = m; bus.OFFSET = o; bus.THRESH = t;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
  endtask

  initial begin
    int fd_cnt, out_cnt, fd_at;
    logic [47:0] rd;

    vecs[0] = '{2'd0, 8'h00, 8'h00, 48'h102030405060, 48'h102030405060};
    vecs[1] = '{2'd1, 8'h0A, 8'h00, 48'hFA058000FF7F, 48'hFF0F8A0AFF89};
    vecs[2] = '{2'd1, 8'hF6, 8'h00, 48'hFA058000FF7F, 48'hF0007600F575};
    vecs[3] = '{2'd2, 8'h00, 8'h00, 48'h123400FF8000, 48'hEDCBFF007FFF};
    vecs[4] = '{2'd3, 8'h00, 8'h64, 48'h646464FFFFFF, 48'hFFFFFFFFFFFF};
    vecs[5] = '{2'd3, 8'h00, 8'h65, 48'h646464FFFFFF, 48'h000000FFFFFF};
    vecs[6] = '{2'd3, 8'h00, 8'hFF, 48'hFFFFFFFEFEFE, 48'hFFFFFF000000};
    vecs[7] = '{2'd1, 8'h80, 8'h00, 48'h80FF7F00C081, 48'h007F00004001};

    set_pair(1'b0, 48'h0);
    set_cfg(2'd0, 8'h00, 8'h00);
    do_reset();
    check("reset_state", dut_out(), 50'h0);

    // Table: each vector is pair 0 of a fresh frame.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      set_cfg(vecs[i].mode, vecs[i].off, vecs[i].thr);
      set_pair(1'b1, vecs[i].din);
      tick();
      set_pair(1'b0, 48'h0);
      tick();
      check($sformatf("vec%0d", i), {bus.hsync, dut_out()}, {1'b1, 1'b1, 1'b0, vecs[i].dout});
    end

    // Pass mode, four back-to-back pairs forming one frame.
    do_reset();
    set_cfg(2'd0, 8'h00, 8'h00);
    for (int t = 0; t < 5; t++) begin
      if (t < 4) set_pair(1'b1, {8'h10 + 8'(t), 40'hA1B2C3D4E5});
      else       set_pair(1'b0, 48'h0);
      tick();
      if (t >= 1) begin
        check("pass_r0", bus.DATA_WRITE_R0, 8'h0F + 8'(t));
        check("pass_fd", bus.frame_done, t == 4);
      end
    end

    // Brightness over two back-to-back frames; mid-frame OFFSET change ignored.
    do_reset();
    set_cfg(2'd1, 8'h0A, 8'h00);
    for (int t = 0; t < 9; t++) begin
      bus.OFFSET = (t == 0) ? 8'h0A : 8'hF6;
      if (t < 8) set_pair(1'b1, 48'hFA0500000000);
      else       set_pair(1'b0, 48'h0);
      tick();
      if (t >= 1) begin
        check("bright_r0", bus.DATA_WRITE_R0, (t - 1 < 4) ? 8'hFF : 8'hF0);
        check("bright_g0", bus.DATA_WRITE_G0, (t - 1 < 4) ? 8'h0F : 8'h00);
      end
    end

    // Invert, MODE switched to pass at pair 2: takes effect only at next pair 0.
    do_reset();
    for (int t = 0; t < 6; t++) begin
      bus.MODE = (t < 2) ? 2'd2 : 2'd0;
      if (t < 5) set_pair(1'b1, 48'h124040404000);
      else       set_pair(1'b0, 48'h0);
      tick();
      if (t >= 1) begin
        check("inv_r0", bus.DATA_WRITE_R0, (t - 1 < 4) ? 8'hED : 8'h12);
        check("inv_b1", bus.DATA_WRITE_B1, (t - 1 < 4) ? 8'hFF : 8'h00);
      end
    end

    // Gapped pairs, then reset with a pair in flight (and hsync_in high during reset).
    do_reset();
    set_cfg(2'd0, 8'h00, 8'h00);
    set_pair(1'b1, 48'h111111111111); tick();
    check("gap_idle0", bus.hsync, 1'b0);
    set_pair(1'b0, 48'h0); tick();
    check("gap_p0", {bus.hsync, bus.DATA_WRITE_R0}, {1'b1, 8'h11});
    set_pair(1'b1, 48'h222222222222); tick();
    check("gap_zero", dut_out(), 50'h0);
    HRESET = 1'b1;
    set_pair(1'b1, 48'h333333333333); tick();
    HRESET = 1'b0;
    check("rst_out", dut_out(), 50'h0);
    set_pair(1'b0, 48'h0);
    for (int t = 0; t < 3; t++) begin
      tick();
      check("rst_flush", bus.hsync, 1'b0);
    end
    fd_cnt = 0; out_cnt = 0; fd_at = 0;
    for (int t = 0; t < 10; t++) begin
      if ((t % 2 == 0) && (t < 8)) set_pair(1'b1, {8'(t), 40'h0102030405});
      else                         set_pair(1'b0, 48'h0);
      tick();
      check("gap_hsync", bus.hsync, (t >= 1) && ((t - 1) % 2 == 0) && (t - 1 < 8));
      if (bus.hsync) out_cnt++;
      if (bus.frame_done) begin fd_cnt++; fd_at = out_cnt; end
    end
    check("post_rst_outs", out_cnt, 4);
    check("post_rst_fd_cnt", fd_cnt, 1);
    check("post_rst_fd_at", fd_at, 4);

    // Randomized traffic against the model, occasional resets.
    for (int n = 0; n < 400; n++) begin
      HRESET = ($urandom_range(0, 63) == 0);
      rd = {16'($urandom()), $urandom()};
      set_pair($urandom_range(0, 3) != 0, rd);
      set_cfg(2'($urandom_range(0, 3)), 8'($urandom()), 8'($urandom()));
      tick();
    end
    HRESET = 1'b0;
    set_pair(1'b0, 48'h0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_pair_filter.md
# pixel_pair_filter

Point-operation filter that sits directly upstream of the BMP writer stage. Consumes a stream of two RGB pixels per valid cycle (`hsync_in`) and produces the same two-pixel stream with a 2-cycle pipeline delay. The output is either passed through, brightness-adjusted with saturation, inverted, or thresholded. Configuration is latched once per frame, and a `frame_done` pulse marks the last output pair of each frame.

## Interface
Parameters:
- `WIDTH`, 340, pixels per line; must be even.
- `HEIGHT`, 230, lines per frame.

Ports:
- `HCLK` in 1: the block's single clock; all logic is on its rising edge.
- `HRESET` in 1: synchronous, active-high reset.
- `hsync_in` in 1: input pair valid.
- `DATA_R0`, `DATA_G0`, `DATA_B0`, `DATA_R1`, `DATA_G1`, `DATA_B1` in 8 each: even/odd pixel channels.
- `MODE` in 2: 0 pass, 1 brightness, 2 invert, 3 threshold.
- `OFFSET` in 8: signed two's-complement brightness offset.
- `THRESH` in 8: threshold level.
- `hsync` out 1: output pair valid.
- `DATA_WRITE_R0`, `DATA_WRITE_G0`, `DATA_WRITE_B0`, `DATA_WRITE_R1`, `DATA_WRITE_G1`, `DATA_WRITE_B1` out 8 each: processed channels.
- `frame_done` out 1: one-cycle pulse coincident with the last output pair of a frame.

## Operation
- **Pair counter.** `pair_cnt` counts `0 .. WIDTH*HEIGHT/2-1`.
  - Increments on each cycle with `hsync_in`=1.
  - Wraps to 0 after the terminal count.
  - Width: clog2(WIDTH*HEIGHT/2).
- **Config latch.** `MODE`, `OFFSET` and `THRESH` are captured into `cfg_*` registers on any cycle with `hsync_in`=1 and `pair_cnt`=0.
  - The captured values are used for that pair and for every later pair of the frame.
  - Input changes mid-frame are ignored.
  - After reset, `cfg_*` = 0 (pass-through).
- **Per-channel operations** (8-bit in, 8-bit out; all six channels are processed identically):
  - Pass: unchanged.
  - Brightness: 10-bit signed sum x + sext(`OFFSET`), clamped to [0,255].
  - Invert: 255 − x.
- **Threshold** (per pixel, not per channel):
  - gray = (R + 2G + B) >> 2, with a 10-bit intermediate.
  - If gray ≥ `THRESH`, all three channels become 255; otherwise all three become 0.
- **Two-stage pipeline.**
  - Stage 1 registers the input channels and the 10-bit intermediates (sum, gray) together with the valid bit and a `last` flag (`pair_cnt` at terminal count).
  - Stage 2 performs clamp/select and registers the outputs.
  - A stage loads 0 into its data registers when its incoming valid is 0, so data outputs are 0 whenever `hsync`=0.
- **No backpressure.** The downstream stage accepts every valid pair, and input pairs may arrive back-to-back or with arbitrary gaps.

## Timing
- Latency: a pair presented with `hsync_in`=1 at edge N appears with `hsync`=1 after edge N+2. Throughput is one pair per cycle.
- `frame_done`=1 during exactly the cycle in which `hsync`=1 carries pair index `WIDTH*HEIGHT/2-1`; otherwise 0.
- Back-to-back frames: pair 0 of the next frame may follow the terminal pair with no gap. The new config applies to that pair, and the previous frame's final two pairs still use the old config, because the config travels with the pipeline as `cfg` registered into stage 1.
- Reset:
  - On the edge with `HRESET`=1, all outputs become 0, `pair_cnt`=0, and `cfg_*`=0.
  - In-flight pairs are discarded and never emitted.
  - The first valid pair after reset is pair 0 of a new frame.
- Simultaneous events: `hsync_in`=1 during `HRESET`=1 is ignored.

## Structure
- Package `imgproc_pkg`:
  - `MODE_PASS`/`MODE_BRIGHT`/`MODE_INV`/`MODE_THR` localparams.
  - `PIX_W`=8.
  - Pair-count width function.
- Sub-module `pixel_op`: one RGB pixel through both pipeline stages (intermediates, clamp, select). Instantiated twice, for pixel 0 and pixel 1.
- The top level holds the counter, the config latch, and the valid/`last` pipeline.

## Test plan
- Bench parameters: `WIDTH`=4, `HEIGHT`=2, giving 4 pairs per frame.
- Pass mode: four back-to-back pairs with R0=0x10, incremented by 1 per pair → identical data out 2 cycles later; `frame_done` high only with the 4th output pair.
- Brightness: `OFFSET`=+10 with R0=250, G0=5; then `OFFSET`=−10 (0xF6) next frame with the same data → 255/15, then 240/0.
- Invert: R0=0x12, B1=0x00 → 0xED, 0xFF. Changing `MODE` to 0 at pair 2 of the same frame has no effect until the next pair 0.
- Threshold: pixel (100,100,100) with `THRESH`=100 → (255,255,255); `THRESH`=101 → (0,0,0). Pixel (255,255,255) → gray 255, so its output is 255 for any `THRESH`.
- Gapped input plus reset mid-frame:
  - Pairs arrive with 1-cycle gaps → `hsync` has the same gaps and data is 0 in the gaps.
  - Assert `HRESET` after pair 1 → nothing is emitted afterwards.
  - The next 4 pairs form a full frame with `frame_done` on the 4th.
